// File: rtl/hera_pkg.sv
// Shared definitions for the HERA load/store stage.
package hera_pkg;

  localparam int unsigned DATA_W      = 16;
  localparam int unsigned REG_W       = 4;
  localparam int unsigned DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE
  } lsu_state_e;

endpackage

// File: rtl/hera_lsu_if.sv
// Data-memory request/acknowledge bus between the LSU and the memory.
interface hera_lsu_if;
  import hera_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/hera_lsu_timer.sv
// Access timeout counter: counts while enabled, clears when requested,
// flags expiry when the count reaches LIMIT.
module hera_lsu_timer #(
  parameter int unsigned LIMIT = 63
) (
  input  logic clk,
  input  logic rst_s,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [15:0] cnt;

  // Count up while enabled; clear has priority.
  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= cnt + 16'd1;
  end

  assign expired = (cnt == 16'(LIMIT));

endmodule

// File: rtl/hera_lsu.sv
// HERA load/store stage: issues one memory access at a time over a
// req/ack bus and writes loaded words back to the register file.
module hera_lsu
  import hera_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned OFFS_W  = 5
) (
  input  logic              clk,
  input  logic              rst_s,
  input  logic              ld_req,
  input  logic              st_req,
  input  logic [OFFS_W-1:0] offset,
  input  logic [DATA_W-1:0] base,
  input  logic [DATA_W-1:0] st_data,
  input  logic [REG_W-1:0]  rd_in,
  hera_lsu_if.master        mem,
  output logic [DATA_W-1:0] load,
  output logic              load_en,
  output logic [REG_W-1:0]  load_rd,
  output logic              busy,
  output logic              err
);

  lsu_state_e        state_q, state_d;
  logic              accept, illegal, timed_out, expired;
  logic              we_q;
  logic [DATA_W-1:0] addr_q, wdata_q, load_q;
  logic [REG_W-1:0]  rd_q, load_rd_q;
  logic              err_q;

  hera_lsu_timer #(.LIMIT(TIMEOUT - 1)) u_timer (
    .clk     (clk),
    .rst_s   (rst_s),
    .clr     (state_q != ST_REQ),
    .en      (state_q == ST_REQ),
    .expired (expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode; DONE behaves like IDLE for new requests so a
  // back-to-back access can start in the writeback cycle.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    illegal   = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (ld_req ^ st_req) begin
          accept  = 1'b1;
          state_d = ST_REQ;
        end else begin
          illegal = ld_req & st_req;
        end
      end
      ST_REQ: begin
        if (mem.mem_ack) begin
          state_d = ST_DONE;
        end else if (expired) begin
          state_d   = ST_IDLE;
          timed_out = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture, load writeback data and the error pulse.
  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      load_q    <= '0;
      load_rd_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= illegal | timed_out;
      if (accept) begin
        we_q    <= st_req;
        addr_q  <= base + DATA_W'(offset);
        wdata_q <= st_data;
        rd_q    <= rd_in;
      end
      if (state_q == ST_REQ && mem.mem_ack && !we_q) begin
        load_q    <= mem.mem_rdata;
        load_rd_q <= rd_q;
      end
    end
  end

  assign mem.mem_req   = (state_q == ST_REQ);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign busy    = (state_q == ST_REQ);
  assign load_en = (state_q == ST_DONE) && !we_q;
  assign load    = load_q;
  assign load_rd = load_rd_q;
  assign err     = err_q;

endmodule
